// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Included by the loader top and its byte packer.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int         BYTE_W     = 8;
  localparam int         WORD_BYTES = 4;
  localparam logic [7:0] CHK_INIT   = 8'h00;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words.
// It emits word_out with a one-cycle word_valid after the fourth byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         byte_valid,
  input  logic [BYTE_W-1:0]            byte_in,
  output logic [1:0]                   byte_idx,
  output logic                         word_valid,
  output logic [BYTE_W*WORD_BYTES-1:0] word_out
);

  localparam int ACC_W  = BYTE_W * (WORD_BYTES - 1);
  localparam int WORD_W = BYTE_W * WORD_BYTES;

  logic [1:0]        idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              vld_q, vld_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    acc_d  = acc_q;
    vld_d  = 1'b0;
    word_d = word_q;
    // clear restarts byte alignment; the last emitted word stays visible.
    if (!clear) begin
      idx_d = '0;
      acc_d = '0;
    end else if (byte_valid) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    acc_d[7:0]   = byte_in;
        2'd1:    acc_d[15:8]  = byte_in;
        2'd2:    acc_d[23:16] = byte_in;
        default: begin
          vld_d  = 1'b1;
          word_d = {byte_in, acc_q};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q  <= '0;
      acc_q  <= '0;
      vld_q  <= 1'b0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      vld_q  <= vld_d;
      word_q <= word_d;
    end
  end

  assign byte_idx   = idx_q;
  assign word_valid = vld_q;
  assign word_out   = word_q;

endmodule

// File: rtl/imem_loader.sv
// Frame parser: 2-byte length, program words, XOR checksum.
// It writes words to instruction memory and releases core_hold when the checksum matches.
// in_valid/in_ready: a byte moves only on a clock edge where both are 1.
// in_byte must be stable while in_valid is 1.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded
);

  localparam logic [15:0] DEPTH_LEN = 16'(DEPTH);

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic              core_hold_q, core_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic [15:0]       len_full;
  logic [1:0]        pk_idx;
  logic              pk_valid;
  logic [31:0]       pk_word;

  assign xfer     = in_valid && in_ready_q;
  assign len_full = {in_byte, len_lo_q};

  // The packer is held cleared outside DATA, so every frame starts word-aligned.
  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_q == DATA),
    .byte_valid (xfer && (state_q == DATA)),
    .byte_in    (in_byte),
    .byte_idx   (pk_idx),
    .word_valid (pk_valid),
    .word_out   (pk_word)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    chk_d    = chk_q;
    addr_d   = addr_q;
    case (state_q)
      LEN_LO: if (xfer) begin
        len_lo_d = in_byte;
        state_d  = LEN_HI;
      end
      LEN_HI: if (xfer) begin
        if (len_full == '0 || len_full > DEPTH_LEN) begin
          state_d = ERROR;
        end else begin
          len_d   = len_full[CNT_W-1:0];
          state_d = DATA;
        end
      end
      DATA: if (xfer) begin
        chk_d = chk_q ^ in_byte;
        // The address is captured alongside the packer's word so both land in the same cycle.
        if (pk_idx == 2'd3) begin
          addr_d = cnt_q[ADDR_W-1:0];
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == len_q) state_d = CHECK;
        end
      end
      CHECK: if (xfer) begin
        state_d = (in_byte == chk_q) ? DONE : ERROR;
      end
      default: ;
    endcase
    in_ready_d  = (state_d != DONE) && (state_d != ERROR);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
    core_hold_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= LEN_LO;
      len_lo_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      chk_q       <= CHK_INIT;
      addr_q      <= '0;
      in_ready_q  <= 1'b1;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      addr_q      <= addr_d;
      in_ready_q  <= in_ready_d;
      core_hold_q <= core_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = pk_valid;
  assign wr_addr      = addr_q;
  assign wr_data      = pk_word;
  assign core_hold    = core_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = cnt_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the instruction memory and program counter of the single-cycle RV32I core.
- Accepts a framed byte stream: 2-byte little-endian word count, then the program words as little-endian bytes, then a checksum byte.
- Writes each assembled 32-bit word into instruction memory.
- Holds the core in reset until a frame completes with a valid checksum.

Parameters:
- DEPTH, 1024, instruction memory depth in 32-bit words; must equal the instruction_memory depth.
- ADDR_W, $clog2(DEPTH), word-address width.
- CNT_W, ADDR_W+1, width of the word counter (holds the value DEPTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  byte on in_byte is offered.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  word to write.
- core_hold  out  1  active-high; keeps the pc/core in reset while 1.
- done  out  1  frame loaded and checksum correct (sticky).
- error  out  1  frame rejected (sticky).
- words_loaded  out  CNT_W  number of words written so far.

Behaviour:
- Reset (reset==0 at a clock edge) sets state=LEN_LO, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, core_hold=1, done=0, error=0, words_loaded=0, checksum=0, byte_idx=0.
- Reset mid-frame aborts the frame. Words already written stay in memory and are not cleared.
- A byte transfer occurs only when in_valid && in_ready at a clock edge. With in_ready=0, in_valid and in_byte are ignored.
- State LEN_LO: on transfer, latch len[7:0]; go to LEN_HI.
- State LEN_HI: on transfer, latch len[15:8].
  - len==0 or len>DEPTH: go to ERROR.
  - Otherwise: go to DATA with byte_idx=0.
- State DATA: each transfer places the byte at word bits [8*byte_idx+7 : 8*byte_idx] and XORs it into checksum. byte_idx wraps 3->0.
  - On the transfer with byte_idx==3, in the next cycle: wr_en=1 for exactly one cycle, wr_addr=word index, wr_data={b3,b2,b1,b0}.
  - words_loaded increments in the same cycle wr_en is high.
  - Write latency is 1 cycle after the 4th byte. Back-to-back bytes sustain 1 byte per cycle.
  - After the last word's 4th byte, go to CHECK.
- State CHECK: on transfer, compare in_byte with checksum (XOR of data bytes only, initial 0x00).
  - Equal: go to DONE.
  - Not equal: go to ERROR.
- State DONE: in_ready=0, done=1, core_hold=0. Held until reset.
- State ERROR: in_ready=0, error=1, core_hold=1. Held until reset.
- done and error are never both 1.
- wr_addr never exceeds DEPTH-1. The word index is ADDR_W bits and is bounded by the len check.
- A pending final wr_en completes in the cycle the FSM enters CHECK.

Decomposition:
- Package imem_loader_pkg: state enum (LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR), BYTE_W=8, WORD_BYTES=4, CHK_INIT=8'h00.
- Sub-module byte_packer: shifts in bytes and emits the word plus a one-cycle word_valid. It has synchronous active-low reset and clear inputs.
- The FSM, length check, checksum and counters live in imem_loader.

Test Plan:
- Single word: stream 01 00 13 05 A0 00 B6, valid every cycle.
  - Expect one wr_en with wr_addr=0, wr_data=32'h00A00513, one cycle after byte 0x00.
  - Then done=1, core_hold=0, words_loaded=1, in_ready=0.
- Two words with random in_valid gaps: 02 00, then 93 00 50 00 (0x00500093), 13 01 30 00 (0x00300113), checksum byte = XOR of the 8 data bytes.
  - Expect writes at addr 0 then 1 with those values, and done=1.
- Bad lengths: 00 00 -> error=1 after the LEN_HI byte; 01 04 (1025) -> error=1.
  - In both cases no wr_en pulse, core_hold=1, in_ready=0.
- Bad checksum: the single-word frame with a final byte B7 instead of B6.
  - Expect the word written to addr 0, then error=1, done=0, core_hold=1.
- Reset mid-frame: send 01 00 13 05, assert reset low for 1 cycle.
  - Expect all outputs at reset values.
  - Then the full single-word frame loads correctly with done=1.
- Full depth: len=00 04 (1024), 4096 data bytes back-to-back.
  - Expect 1024 wr_en pulses, last wr_addr=1023, words_loaded=1024, done=1 on the correct checksum.
